// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: 10 ms prescaler feeding a 4-digit BCD chain (SS.hh),
// start/stop and lap/clear button handling, lap freeze and wrap pulse.
//
// state | meaning
// IDLE  | cleared, waiting for start
// RUN   | counting, display shows live digits
// LAP   | counting, display frozen at lap digits
// STOP  | paused, prescaler and digits held
module stopwatch_ctrl #(
  parameter int P_TICK = 320000,
  parameter int P_PW   = 19
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       btn_ss,
  input  logic       btn_lap,
  output logic [3:0] t_10ms,
  output logic [3:0] t_100ms,
  output logic [3:0] t_1s,
  output logic [3:0] t_10s,
  output logic       running,
  output logic       lap_active,
  output logic       ovf
);

  typedef enum logic [1:0] {IDLE, RUN, LAP, STOP} state_t;

  localparam logic [P_PW-1:0] PRESC_TC = P_PW'(P_TICK - 1);

  state_t                state_q, state_d;
  logic [P_PW-1:0]       presc_q, presc_d;
  logic [3:0][3:0]       live_q, live_d;
  logic [3:0][3:0]       lap_q, lap_d;
  logic                  btn_ss_d, btn_lap_d;
  logic                  ovf_q, ovf_d;
  logic                  ss_ev, lap_ev;
  logic                  counting, tick, carry;

  assign ss_ev    = btn_ss & ~btn_ss_d;
  assign lap_ev   = btn_lap & ~btn_lap_d;
  assign counting = (state_q == RUN) || (state_q == LAP);
  assign tick     = counting && (presc_q == PRESC_TC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      live_q    <= '0;
      lap_q     <= '0;
      ovf_q     <= 1'b0;
      // Held buttons must not look like a fresh press once reset releases.
      btn_ss_d  <= 1'b1;
      btn_lap_d <= 1'b1;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      live_q    <= live_d;
      lap_q     <= lap_d;
      ovf_q     <= ovf_d;
      btn_ss_d  <= btn_ss;
      btn_lap_d <= btn_lap;
    end
  end

  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    live_d  = live_q;
    lap_d   = lap_q;
    ovf_d   = 1'b0;
    carry   = tick;

    if (counting) begin
      presc_d = tick ? '0 : presc_q + P_PW'(1);
    end

    // Ripple the tick through the digits; a carry out of the top digit is the wrap.
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (live_q[i] >= 4'd9) begin
          live_d[i] = 4'd0;
        end else begin
          live_d[i] = live_q[i] + 4'd1;
          carry     = 1'b0;
        end
      end
    end
    ovf_d = carry;

    case (state_q)
      IDLE: begin
        if (ss_ev) state_d = RUN;
      end
      RUN: begin
        if (ss_ev) begin
          state_d = STOP;
        end else if (lap_ev) begin
          state_d = LAP;
          lap_d   = live_q;
        end
      end
      LAP: begin
        if (ss_ev) begin
          state_d = STOP;
        end else if (lap_ev) begin
          state_d = RUN;
        end
      end
      STOP: begin
        if (ss_ev) begin
          state_d = RUN;
        end else if (lap_ev) begin
          state_d = IDLE;
          presc_d = '0;
          live_d  = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    if (state_q == LAP) begin
      {t_10s, t_1s, t_100ms, t_10ms} = lap_q;
    end else begin
      {t_10s, t_1s, t_100ms, t_10ms} = live_q;
    end
  end

  assign running    = counting;
  assign lap_active = (state_q == LAP);
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl with a 4-cycle prescaler.
// Expected outputs are queued as stimulus is driven, observed outputs are queued when sampled.
module tb_stopwatch_ctrl;

  logic       clk;
  logic       rst;
  logic       btn_ss;
  logic       btn_lap;
  logic [3:0] t_10ms, t_100ms, t_1s, t_10s;
  logic       running, lap_active, ovf;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string       tag;
    logic [18:0] v;
  } ent_t;

  ent_t        exp_q[$];
  logic [18:0] obs_q[$];

  stopwatch_ctrl #(.P_TICK(4), .P_PW(19)) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_ss     (btn_ss),
    .btn_lap    (btn_lap),
    .t_10ms     (t_10ms),
    .t_100ms    (t_100ms),
    .t_1s       (t_1s),
    .t_10s      (t_10s),
    .running    (running),
    .lap_active (lap_active),
    .ovf        (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {10s,1s,100ms,10ms digits, running, lap_active, ovf}
  function automatic logic [18:0] ev(input logic [15:0] bcd, input logic r, input logic l,
                                     input logic o);
    return {bcd, r, l, o};
  endfunction

  function automatic logic [18:0] obs_now();
    return {t_10s, t_1s, t_100ms, t_10ms, running, lap_active, ovf};
  endfunction

  task automatic clk_n(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push_exp(input string tag, input logic [18:0] v);
    ent_t e;
    e.tag = tag;
    e.v   = v;
    exp_q.push_back(e);
  endtask

  // Buttons are asserted for the first edge of the step only; outputs sampled after n edges.
  task automatic drive_step(input string tag, input logic ss, input logic lap, input int n,
                            input logic [18:0] v);
    push_exp(tag, v);
    btn_ss  = ss;
    btn_lap = lap;
    clk_n(1);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    if (n > 1) clk_n(n - 1);
    obs_q.push_back(obs_now());
  endtask

  task automatic test_reset();
    ent_t        e;
    logic [18:0] o;
    rst = 1'b1;
    drive_step("reset_state", 0, 0, 3, ev(16'h0000, 0, 0, 0));
    rst = 1'b0;
    drive_step("reset_release", 0, 0, 1, ev(16'h0000, 0, 0, 0));
    drive_step("idle_no_start", 0, 0, 4, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic test_run();
    ent_t        e;
    logic [18:0] o;
    drive_step("run_start", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("run_39", 0, 0, 39, ev(16'h0009, 1, 0, 0));
    drive_step("run_40", 0, 0, 1, ev(16'h0010, 1, 0, 0));
    drive_step("run_stop", 1, 0, 1, ev(16'h0010, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  // Prescaler was at 1 when stopped, so after resume the next tick is three edges away.
  task automatic test_stop_hold();
    ent_t        e;
    logic [18:0] o;
    drive_step("stop_hold", 0, 0, 100, ev(16'h0010, 0, 0, 0));
    drive_step("resume", 1, 0, 1, ev(16'h0010, 1, 0, 0));
    drive_step("resume_2", 0, 0, 2, ev(16'h0010, 1, 0, 0));
    drive_step("resume_tick", 0, 0, 1, ev(16'h0011, 1, 0, 0));
    drive_step("stop_again", 1, 0, 2, ev(16'h0011, 0, 0, 0));
    drive_step("clear", 0, 1, 1, ev(16'h0000, 0, 0, 0));
    drive_step("clear_idle", 0, 0, 5, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic test_lap();
    ent_t        e;
    logic [18:0] o;
    drive_step("lap_start", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("lap_run5", 0, 0, 20, ev(16'h0005, 1, 0, 0));
    drive_step("lap_enter", 0, 1, 1, ev(16'h0005, 1, 1, 0));
    drive_step("lap_frozen", 0, 0, 8, ev(16'h0005, 1, 1, 0));
    drive_step("lap_exit", 0, 1, 1, ev(16'h0007, 1, 0, 0));
    drive_step("lap_live", 0, 0, 2, ev(16'h0008, 1, 0, 0));
    drive_step("lap2_enter", 0, 1, 1, ev(16'h0008, 1, 1, 0));
    drive_step("lap2_frozen", 0, 0, 4, ev(16'h0008, 1, 1, 0));
    drive_step("lap_to_stop", 1, 0, 1, ev(16'h0009, 0, 0, 0));
    drive_step("lap_stop_hold", 0, 0, 3, ev(16'h0009, 0, 0, 0));
    drive_step("lap_clear", 0, 1, 1, ev(16'h0000, 0, 0, 0));
    drive_step("lap_idle", 0, 0, 2, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic test_simultaneous();
    ent_t        e;
    logic [18:0] o;
    drive_step("sim_start", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("sim_run2", 0, 0, 8, ev(16'h0002, 1, 0, 0));
    drive_step("sim_both", 1, 1, 1, ev(16'h0002, 0, 0, 0));
    drive_step("sim_hold", 0, 0, 10, ev(16'h0002, 0, 0, 0));
    drive_step("sim_clear", 0, 1, 1, ev(16'h0000, 0, 0, 0));
    drive_step("sim_idle", 0, 0, 2, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  // Tick k lands on edge 4k after the start press; tick 10000 wraps 99.99 to 00.00.
  task automatic test_ovf();
    ent_t        e;
    logic [18:0] o;
    drive_step("ovf_start", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("ovf_0999", 0, 0, 3996, ev(16'h0999, 1, 0, 0));
    drive_step("ovf_1000", 0, 0, 4, ev(16'h1000, 1, 0, 0));
    drive_step("ovf_9999", 0, 0, 35999, ev(16'h9999, 1, 0, 0));
    drive_step("ovf_wrap", 0, 0, 1, ev(16'h0000, 1, 0, 1));
    drive_step("ovf_pulse_end", 0, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("ovf_continue", 0, 0, 3, ev(16'h0001, 1, 0, 0));
    drive_step("ovf_stop", 1, 0, 2, ev(16'h0001, 0, 0, 0));
    drive_step("ovf_clear", 0, 1, 1, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic test_held_reset();
    ent_t        e;
    logic [18:0] o;
    drive_step("hr_start", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("hr_run1", 0, 0, 6, ev(16'h0001, 1, 0, 0));
    push_exp("hr_reset_mid_run", ev(16'h0000, 0, 0, 0));
    rst     = 1'b1;
    btn_ss  = 1'b1;
    btn_lap = 1'b1;
    clk_n(1);
    obs_q.push_back(obs_now());
    clk_n(2);
    push_exp("hr_held_release", ev(16'h0000, 0, 0, 0));
    rst = 1'b0;
    clk_n(5);
    obs_q.push_back(obs_now());
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    drive_step("hr_settle", 0, 0, 2, ev(16'h0000, 0, 0, 0));
    drive_step("hr_run", 1, 0, 1, ev(16'h0000, 1, 0, 0));
    drive_step("hr_tick", 0, 0, 6, ev(16'h0001, 1, 0, 0));
    drive_step("hr_stop", 1, 0, 2, ev(16'h0001, 0, 0, 0));
    drive_step("hr_clear", 0, 1, 1, ev(16'h0000, 0, 0, 0));
    drive_step("hr_idle", 0, 0, 10, ev(16'h0000, 0, 0, 0));
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      o = obs_q.pop_front();
      checks++;
      if (o !== e.v) begin
        errors++;
        $display("FAIL %s: observed %h expected %h", e.tag, o, e.v);
      end
    end
  endtask

  initial begin
    rst     = 1'b1;
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    test_reset();
    test_run();
    test_stop_hold();
    test_lap();
    test_simultaneous();
    test_ovf();
    test_held_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
